// File: rtl/pulse_delay_pkg.sv
// Shared constants and types for the pulse delay responder.
// Stamp and count widths are sized for the largest legal DELAY and DEPTH.
package pulse_delay_pkg;

  localparam int unsigned DefDelay = 4;
  localparam int unsigned DefDepth = 4;
  localparam int unsigned MaxDelay = 15;
  localparam int unsigned MaxDepth = 16;

  localparam int unsigned StampW = $clog2(MaxDelay) + 1;
  localparam int unsigned CountW = $clog2(MaxDepth) + 1;

  typedef logic [StampW-1:0] stamp_t;
  typedef logic [CountW-1:0] count_t;

endpackage

// File: rtl/stamp_fifo.sv
// Synchronous FIFO of due stamps; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module stamp_fifo
  import pulse_delay_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  stamp_t wdata,
  input  logic   pop,
  output stamp_t rdata,
  output logic   full,
  output logic   empty,
  output count_t count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] LastIdx = PtrW'(DEPTH - 1);

  stamp_t          mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  count_t          count_q;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == LastIdx) ? '0 : p + PtrW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == count_t'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= next_ptr(wptr_q);
      if (do_pop)  rptr_q <= next_ptr(rptr_q);
      count_q <= count_q + count_t'(do_push) - count_t'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/pulse_delay_responder.sv
// Answers each accepted request with a one-cycle b pulse DELAY edges later,
// tracking pending requests as due stamps against a free-running counter.
module pulse_delay_responder
  import pulse_delay_pkg::*;
#(
  parameter int unsigned DELAY = DefDelay,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        a,
  output logic        b,
  output logic [4:0]  outstanding,
  output logic        drop,
  output logic [15:0] resp_cnt
);

  localparam int unsigned CntW = $clog2(DELAY) + 1;

  logic [CntW-1:0] cnt_q, cnt_next, due;
  logic            b_q, drop_q;
  logic [15:0]     resp_cnt_q;

  stamp_t head;
  count_t fifo_count;
  logic   fifo_full, fifo_empty;
  logic   req, mature, accept;

  assign cnt_next = cnt_q + CntW'(1);
  assign due      = cnt_q + CntW'(DELAY);

  // Popping one cycle early lets the registered b line up with the due edge.
  assign req    = en && a;
  assign mature = !fifo_empty && (head == stamp_t'(cnt_next));
  assign accept = req && (!fifo_full || mature);

  stamp_fifo #(
    .DEPTH (DEPTH)
  ) u_stamp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .wdata (stamp_t'(due)),
    .pop   (mature),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      b_q        <= 1'b0;
      drop_q     <= 1'b0;
      resp_cnt_q <= '0;
    end else begin
      cnt_q      <= cnt_next;
      b_q        <= mature;
      resp_cnt_q <= resp_cnt_q + 16'(mature);
      if (req && !accept) drop_q <= 1'b1;
    end
  end

  assign b           = b_q;
  assign drop        = drop_q;
  assign resp_cnt    = resp_cnt_q;
  assign outstanding = fifo_count;

endmodule

// File: tb/tb_pulse_delay_responder.sv
// Randomized bench for pulse_delay_responder: a default instance and a DEPTH=2
// instance share stimulus and are checked against a queue-of-due-edges model.
module tb_pulse_delay_responder;

  localparam int unsigned Delay = 4;
  localparam int NInst = 2;
  localparam int NRand = 3000;
  localparam int NEdges = 30 + NRand + 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic a = 1'b0;

  logic        b_w    [NInst];
  logic [4:0]  out_w  [NInst];
  logic        drop_w [NInst];
  logic [15:0] rc_w   [NInst];

  for (genvar g = 0; g < NInst; g++) begin : g_dut
    pulse_delay_responder #(
      .DELAY (Delay),
      .DEPTH ((g == 0) ? 4 : 2)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .a           (a),
      .b           (b_w[g]),
      .outstanding (out_w[g]),
      .drop        (drop_w[g]),
      .resp_cnt    (rc_w[g])
    );
  end

  always #5 clk = ~clk;

  function automatic int depth_of(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  // Model: each instance holds the absolute edge numbers at which b must be
  // seen; b is high after edge e when a pending request is due at edge e+1.
  int edge_n = 0;
  bit model_valid = 0;
  int dq [NInst][$];
  bit exp_b [NInst];
  int exp_out [NInst];
  bit exp_drop [NInst];
  int exp_rc [NInst];

  always @(posedge clk) begin
    int sz;
    bit pop;
    edge_n++;
    for (int i = 0; i < NInst; i++) begin
      if (rst) begin
        dq[i].delete();
        exp_b[i] = 0;
        exp_drop[i] = 0;
        exp_rc[i] = 0;
        model_valid = 1;
      end else begin
        sz = dq[i].size();
        pop = (sz > 0) && (dq[i][0] == edge_n + 1);
        if (pop) void'(dq[i].pop_front());
        if (en && a) begin
          if (sz < depth_of(i) || pop) dq[i].push_back(edge_n + Delay);
          else exp_drop[i] = 1;
        end
        exp_b[i] = pop;
        exp_rc[i] = (exp_rc[i] + int'(pop)) % 65536;
      end
      exp_out[i] = dq[i].size();
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int inst, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s inst=%0d edge=%0d got=%0d want=%0d", nm, inst, edge_n, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      for (int i = 0; i < NInst; i++) begin
        chk("b", i, {31'b0, b_w[i]}, {31'b0, exp_b[i]});
        chk("outstanding", i, {27'b0, out_w[i]}, exp_out[i]);
        chk("drop", i, {31'b0, drop_w[i]}, {31'b0, exp_drop[i]});
        chk("resp_cnt", i, {16'b0, rc_w[i]}, exp_rc[i]);
      end
      // Hand-derived expectations for the directed prologue.
      case (edge_n)
        2: begin
          chk("lit_rst_b", 0, {31'b0, b_w[0]}, 0);
          chk("lit_rst_out", 0, {27'b0, out_w[0]}, 0);
          chk("lit_rst_drop", 0, {31'b0, drop_w[0]}, 0);
          chk("lit_rst_rc", 0, {16'b0, rc_w[0]}, 0);
        end
        5: begin
          chk("lit_burst_out", 0, {27'b0, out_w[0]}, 3);
          chk("lit_full_out", 1, {27'b0, out_w[1]}, 2);
          chk("lit_full_drop", 1, {31'b0, drop_w[1]}, 1);
        end
        6: chk("lit_first_b", 0, {31'b0, b_w[0]}, 1);
        8: begin
          chk("lit_third_b", 0, {31'b0, b_w[0]}, 1);
          chk("lit_dropped_no_b", 1, {31'b0, b_w[1]}, 0);
        end
        9: begin
          chk("lit_burst_end_b", 0, {31'b0, b_w[0]}, 0);
          chk("lit_burst_rc", 0, {16'b0, rc_w[0]}, 3);
          chk("lit_burst_out0", 0, {27'b0, out_w[0]}, 0);
          chk("lit_full_rc", 1, {16'b0, rc_w[1]}, 2);
          chk("lit_drop_sticky", 1, {31'b0, drop_w[1]}, 1);
        end
        16: begin
          chk("lit_midrst_out", 0, {27'b0, out_w[0]}, 0);
          chk("lit_midrst_drop", 1, {31'b0, drop_w[1]}, 0);
        end
        17: chk("lit_killed_b", 0, {31'b0, b_w[0]}, 0);
        18: chk("lit_killed_b2", 0, {31'b0, b_w[0]}, 0);
        20: chk("lit_postrst_b", 0, {31'b0, b_w[0]}, 1);
        21: chk("lit_postrst_b_end", 0, {31'b0, b_w[0]}, 0);
        26: chk("lit_en_off_b", 0, {31'b0, b_w[0]}, 0);
        27: chk("lit_en_on_b", 0, {31'b0, b_w[0]}, 1);
        28: begin
          chk("lit_en_end_b", 0, {31'b0, b_w[0]}, 0);
          chk("lit_en_rc", 0, {16'b0, rc_w[0]}, 2);
        end
        default: ;
      endcase
    end
  end

  task automatic apply(input int e);
    int dens;
    rst = 1'b0;
    en = 1'b1;
    a = 1'b0;
    if (e <= 30) begin
      case (e)
        1, 2, 12, 30: rst = 1'b1;
        3, 4, 5, 14, 17, 24: a = 1'b1;
        16: begin rst = 1'b1; a = 1'b1; end
        23: begin en = 1'b0; a = 1'b1; end
        default: ;
      endcase
    end else if (e <= 30 + NRand) begin
      dens = 10 + ((e / 200) * 37) % 91;
      a = ($urandom_range(0, 99) < dens);
      en = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 249) == 0);
    end
  endtask

  initial begin
    for (int e = 1; e <= NEdges; e++) begin
      apply(e);
      @(negedge clk);
    end
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
